// File: rtl/button_event_debouncer_if.sv
// Button debouncer signal bundle.
// master drives raw buttons, slave returns debounced events.
interface button_event_debouncer_if #(
  parameter int CHANNELS = 4
);
  logic [CHANNELS-1:0] btn_i;
  logic [CHANNELS-1:0] level_o;
  logic [CHANNELS-1:0] press_o;
  logic [CHANNELS-1:0] release_o;
  logic [CHANNELS-1:0] repeat_o;
  logic                any_press_o;

  modport master (
    output btn_i,
    input  level_o,
    input  press_o,
    input  release_o,
    input  repeat_o,
    input  any_press_o
  );

  modport slave (
    input  btn_i,
    output level_o,
    output press_o,
    output release_o,
    output repeat_o,
    output any_press_o
  );
endinterface

// File: rtl/button_event_debouncer.sv
// Multi-channel button debouncer with press/release
// pulses and optional auto-repeat while held.
module button_event_debouncer #(
  parameter int CHANNELS        = 4,
  parameter int DEBOUNCE_CYCLES = 65536,
  parameter int REPEAT_DELAY    = 0,
  parameter int REPEAT_PERIOD   = 0,
  parameter bit ACTIVE_LOW      = 1'b0
) (
  input logic clk,
  input logic rst,
  button_event_debouncer_if.slave bus
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                        REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = (RMAX > 2) ? $clog2(RMAX) : 1;

  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } state_e;

  logic [CHANNELS-1:0] sync1_q = '0;
  logic [CHANNELS-1:0] sync2_q = '0;
  logic [CHANNELS-1:0] press_nx;
  logic [CHANNELS-1:0] level_v;
  logic [CHANNELS-1:0] press_v;
  logic [CHANNELS-1:0] rel_v;
  logic [CHANNELS-1:0] rpt_v;
  logic                any_press_q = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      any_press_q <= 1'b0;
    end else begin
      sync1_q <= bus.btn_i ^ {CHANNELS{ACTIVE_LOW}};
      sync2_q <= sync1_q;
      any_press_q <= |press_nx;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    state_e          st_q       = IDLE;
    logic [DW-1:0]   db_q       = '0;
    logic [RW-1:0]   rc_q       = '0;
    logic            periodic_q = 1'b0;
    logic            lvl_q      = 1'b0;
    logic            prs_q      = 1'b0;
    logic            rel_q      = 1'b0;
    logic            rpt_q      = 1'b0;
    logic            s;
    logic            db_done;
    logic            rpt_hit;
    logic            rc_run;

    assign s       = sync2_q[i];
    assign db_done = (db_q == DB_LAST);

    // After the first repeat the period limit applies;
    // a zero period means the first repeat was the only one.
    always_comb begin
      rpt_hit = 1'b0;
      rc_run  = 1'b0;
      if (REPEAT_DELAY > 0) begin
        if (!periodic_q) begin
          rpt_hit = (rc_q == RD_LAST);
          rc_run  = 1'b1;
        end else if (REPEAT_PERIOD > 0) begin
          rpt_hit = (rc_q == RP_LAST);
          rc_run  = 1'b1;
        end
      end
    end

    assign press_nx[i] = (st_q == PRESS_WAIT) && s && db_done;

    always_ff @(posedge clk) begin
      if (rst) begin
        st_q       <= IDLE;
        db_q       <= '0;
        rc_q       <= '0;
        periodic_q <= 1'b0;
        lvl_q      <= 1'b0;
        prs_q      <= 1'b0;
        rel_q      <= 1'b0;
        rpt_q      <= 1'b0;
      end else begin
        prs_q <= 1'b0;
        rel_q <= 1'b0;
        rpt_q <= 1'b0;
        case (st_q)
          IDLE: begin
            if (s) begin
              st_q <= PRESS_WAIT;
              db_q <= '0;
            end
          end
          PRESS_WAIT: begin
            if (!s) begin
              st_q <= IDLE;
              db_q <= '0;
            end else if (db_done) begin
              st_q       <= HELD;
              prs_q      <= 1'b1;
              lvl_q      <= 1'b1;
              rc_q       <= '0;
              periodic_q <= 1'b0;
            end else begin
              db_q <= db_q + 1'b1;
            end
          end
          HELD: begin
            if (!s) begin
              st_q <= RELEASE_WAIT;
              db_q <= '0;
            end else if (rpt_hit) begin
              rpt_q      <= 1'b1;
              rc_q       <= '0;
              periodic_q <= 1'b1;
            end else if (rc_run) begin
              rc_q <= rc_q + 1'b1;
            end
          end
          RELEASE_WAIT: begin
            if (s) begin
              st_q <= HELD;
              db_q <= '0;
            end else if (db_done) begin
              st_q  <= IDLE;
              rel_q <= 1'b1;
              lvl_q <= 1'b0;
            end else begin
              db_q <= db_q + 1'b1;
            end
          end
          default: st_q <= IDLE;
        endcase
      end
    end

    assign level_v[i] = lvl_q;
    assign press_v[i] = prs_q;
    assign rel_v[i]   = rel_q;
    assign rpt_v[i]   = rpt_q;
  end

  assign bus.level_o     = level_v;
  assign bus.press_o     = press_v;
  assign bus.release_o   = rel_v;
  assign bus.repeat_o    = rpt_v;
  assign bus.any_press_o = any_press_q;

endmodule

// File: doc/button_event_debouncer.md
BUTTON_EVENT_DEBOUNCER -- requirements
Module: button_event_debouncer

Interface
REQ-001 Parameter CHANNELS, default 4: number of independent button channels, range 1..32.
REQ-002 Parameter DEBOUNCE_CYCLES, default 65536: clocks an input must stay stable to be accepted, minimum 2.
REQ-003 Parameter REPEAT_DELAY, default 0: held clocks before the first repeat pulse; 0 disables auto-repeat.
REQ-004 Parameter REPEAT_PERIOD, default 0: clocks between later repeat pulses; 0 gives one repeat only, ignored when REPEAT_DELAY=0.
REQ-005 Parameter ACTIVE_LOW, default 0: 1 inverts btn before synchronisation.
REQ-006 clk  input  1  clock; all state changes on its rising edge.
REQ-007 rst  input  1  reset; synchronous, active-high.
REQ-008 btn  input  CHANNELS  raw asynchronous button levels.
REQ-009 level  output  CHANNELS  debounced, registered pressed state.
REQ-010 press  output  CHANNELS  one-clock pulse on accepted press.
REQ-011 release  output  CHANNELS  one-clock pulse on accepted release.
REQ-012 repeat  output  CHANNELS  one-clock pulse per auto-repeat tick while held.
REQ-013 any_press  output  1  registered OR of press, same cycle as press.

Function
REQ-014 Each channel SHALL pass btn[i], after optional inversion, through a 2-flop synchroniser; s[i] is the second flop.
REQ-015 Each channel SHALL hold its own FSM (IDLE, PRESS_WAIT, HELD, RELEASE_WAIT), debounce counter and repeat counter; channels share no state.
REQ-016 Counter widths SHALL be clog2 of the largest count needed, so no counter wraps within its range.
REQ-017 IDLE: s=1 -> PRESS_WAIT, debounce counter cleared to 0; s=0 -> stay.
REQ-018 PRESS_WAIT: s=0 -> IDLE, counter 0, no pulse; s=1 with counter=DEBOUNCE_CYCLES-1 -> HELD, press=1, level=1, repeat counter 0; otherwise counter+1.
REQ-019 HELD: s=0 -> RELEASE_WAIT, debounce counter 0, repeat counter frozen; s=1 -> repeat logic per REQ-020.
REQ-020 Repeat (REPEAT_DELAY>0): first repeat pulse when repeat counter reaches REPEAT_DELAY-1, then every REPEAT_PERIOD clocks; counter reloads to 0 on each pulse.
REQ-021 RELEASE_WAIT: s=1 -> HELD, debounce counter 0, no pulse, repeat counter resumes from frozen value; s=0 with counter=DEBOUNCE_CYCLES-1 -> IDLE, release=1, level=0; otherwise counter+1.
REQ-022 press, release and repeat SHALL be registered; each is high for exactly one clock and defaults to 0 in every other cycle.
REQ-023 press and repeat SHALL never be high in the same cycle on one channel.
REQ-024 Press latency: btn stable high from before edge k -> press and level high after edge k+2+DEBOUNCE_CYCLES; release latency is symmetric.
REQ-025 A glitch shorter than DEBOUNCE_CYCLES in PRESS_WAIT or RELEASE_WAIT SHALL produce no output change.
REQ-026 Simultaneous events on several channels SHALL produce pulses on each channel independently, in the same cycle.

Reset
REQ-027 With rst=1 at a rising edge: synchroniser flops 0, all FSMs IDLE, all counters 0, and level, press, release, repeat, any_press all 0 from the next cycle.
REQ-028 Reset mid-operation, in any state, SHALL discard progress with no release pulse; a button held through reset SHALL be re-debounced from IDLE and produce a fresh press.
REQ-029 Power-up initial values SHALL equal the reset values.

Verification (CHANNELS=4, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, ACTIVE_LOW=0)
REQ-030 btn[0] 0->1 before edge 0, held -> press[0]=1 and any_press=1 for one cycle after edge 6; level[0]=1 from then on.
REQ-031 btn[1] high for 3 clocks then low -> press, level and release stay 0 on channel 1.
REQ-032 btn[2] held 40 clocks after press -> repeat[2] pulses at press+10, +13, +16, ... and never in the press cycle; release[2] once, 6 clocks after the btn fall.
REQ-033 btn[3] held, release bounce of 2 clocks low then high -> no release, level[3] stays 1, repeat cadence continues.
REQ-034 btn[0] and btn[3] rise on the same edge -> press[0] and press[3] in the same cycle, any_press one cycle only.
REQ-035 rst pulsed while channel 0 HELD with btn still high -> all outputs 0, no release pulse, fresh press[0] 6 clocks after rst falls.
